// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring division step: bring in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // partial_rem < divisor on entry, so the restored or reduced value fits WIDTH bits.
  always_comb begin
    trial   = {partial_rem, next_bit};
    q_bit   = (trial >= {1'b0, divisor});
    new_rem = q_bit ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle signed/unsigned divider: magnitudes are divided with one restoring
// step per cycle for a fixed WIDTH cycles, then signs are applied on the last step.
module iterative_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             q_bit;

  // A zero divisor never negates the quotient, so it stays all ones; the
  // remainder magnitude negated by the dividend sign reproduces the dividend.
  always_comb begin
    dvd_neg  = is_signed & dividend[WIDTH-1];
    dvs_neg  = is_signed & divisor[WIDTH-1];
    dvs_zero = (divisor == '0);
    dvd_mag  = dvd_neg ? -dividend : dividend;
    dvs_mag  = dvs_neg ? -divisor : divisor;
  end

  divider_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem (rem_reg),
    .divisor     (div_reg),
    .next_bit    (shift_reg[WIDTH-1]),
    .new_rem     (rem_next),
    .q_bit       (q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign quo_next = {shift_reg[WIDTH-2:0], q_bit};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      shift_reg     <= '0;
      div_reg       <= '0;
      rem_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shift_reg    <= dvd_mag;
            div_reg      <= dvs_mag;
            rem_reg      <= '0;
            q_neg_reg    <= (dvd_neg ^ dvs_neg) & ~dvs_zero;
            r_neg_reg    <= dvd_neg;
            count_reg    <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          rem_reg   <= rem_next;
          shift_reg <= quo_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_STEP) begin
            quotient_reg  <= q_neg_reg ? -quo_next : quo_next;
            remainder_reg <= r_neg_reg ? -rem_next : rem_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: directed table, random ops against
// an arithmetic reference model, and handshake/reset sequences.
module tb_iterative_divider;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       is_signed = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [7:0] remainder;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  vec_t vecs[12];

  iterative_divider #(.WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, with the
  // divide-by-zero and signed-overflow results defined for this block.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                output logic [7:0] q, output logic [7:0] r);
    int sa;
    int sb;
    if (b == 8'h00) begin
      q = 8'hFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin
        q = 8'h80;
        r = 8'h00;
      end else begin
        q = 8'(sa / sb);
        r = 8'(sa % sb);
      end
    end
  endfunction

  // Called and returns at 1 time unit after a rising edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [7:0] q, output logic [7:0] r, output int lat);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    check("in_ready_before_accept", in_ready, 1'b1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_checked(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic s, input logic [7:0] eq, input logic [7:0] er);
    logic [7:0] q;
    logic [7:0] r;
    int lat;
    run_op(a, b, s, q, r, lat);
    $display("%s: %s 0x%02h / 0x%02h -> q=0x%02h r=0x%02h lat=%0d (exp q=0x%02h r=0x%02h)",
             tag, s ? "signed" : "unsigned", a, b, q, r, lat, eq, er);
    check({tag, "_quotient"}, q, eq);
    check({tag, "_remainder"}, r, er);
    check({tag, "_latency"}, lat, 8);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] eq;
    logic [7:0] er;
    logic [7:0] hold_q;
    logic [7:0] hold_r;
    int lat;
    int seen;

    vecs[0]  = '{8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00};
    vecs[1]  = '{8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF};
    vecs[2]  = '{8'hF9, 8'h02, 1'b0, 8'h7C, 8'h01};
    vecs[3]  = '{8'h85, 8'h00, 1'b1, 8'hFF, 8'h85};
    vecs[4]  = '{8'h85, 8'h00, 1'b0, 8'hFF, 8'h85};
    vecs[5]  = '{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00};
    vecs[6]  = '{8'h64, 8'h07, 1'b0, 8'h0E, 8'h02};
    vecs[7]  = '{8'h00, 8'h05, 1'b1, 8'h00, 8'h00};
    vecs[8]  = '{8'h7F, 8'h80, 1'b1, 8'h00, 8'h7F};
    vecs[9]  = '{8'h80, 8'h02, 1'b0, 8'h40, 8'h00};
    vecs[10] = '{8'h80, 8'h07, 1'b1, 8'hEE, 8'hFE};
    vecs[11] = '{8'hFF, 8'hFF, 1'b1, 8'h01, 8'h00};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    $display("reset: q=0x%02h r=0x%02h out_valid=%0b in_ready=%0b", quotient, remainder, out_valid, in_ready);
    check("reset_quotient", quotient, 8'h00);
    check("reset_remainder", remainder, 8'h00);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);

    foreach (vecs[i])
      do_checked($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r);

    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      s = 1'($urandom);
      if ($urandom_range(0, 14) == 0) begin
        a = 8'h80;
        b = 8'hFF;
        s = 1'b1;
      end
      model(a, b, s, eq, er);
      do_checked($sformatf("rand%0d", i), a, b, s, eq, er);
    end

    // Stall in DONE with a competing request, then release into a back-to-back op.
    dividend = 8'h64; divisor = 8'h07; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check("stall_latency", lat, 8);
    hold_q = quotient;
    hold_r = remainder;
    dividend = 8'h50; divisor = 8'h03; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      $display("stall cycle %0d: q=0x%02h r=0x%02h out_valid=%0b in_ready=%0b", c, quotient, remainder, out_valid, in_ready);
      check("stall_quotient", quotient, 8'h0E);
      check("stall_remainder", remainder, 8'h02);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
    end
    check("stall_held_q", quotient, hold_q);
    check("stall_held_r", remainder, hold_r);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    $display("handoff: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    check("handoff_out_valid", out_valid, 1'b0);
    check("handoff_in_ready", in_ready, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("next_accept_in_ready", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    $display("back-to-back: 0x50 / 0x03 -> q=0x%02h r=0x%02h lat=%0d", quotient, remainder, lat);
    check("b2b_latency", lat, 8);
    check("b2b_quotient", quotient, 8'h1A);
    check("b2b_remainder", remainder, 8'h02);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;

    // Reset during CALC after four steps: the operation must vanish.
    dividend = 8'hC8; divisor = 8'h03; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; out_ready = 1'b0;
    $display("reset mid-calc: q=0x%02h r=0x%02h out_valid=%0b in_ready=%0b", quotient, remainder, out_valid, in_ready);
    check("calc_reset_out_valid", out_valid, 1'b0);
    check("calc_reset_quotient", quotient, 8'h00);
    check("calc_reset_remainder", remainder, 8'h00);
    check("calc_reset_in_ready", in_ready, 1'b1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      if (out_valid) seen++;
    end
    check("calc_reset_no_result", seen, 0);
    do_checked("after_reset", 8'h64, 8'h07, 1'b0, 8'h0E, 8'h02);

    // Reset while a result waits in DONE.
    dividend = 8'h10; divisor = 8'h03; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    $display("reset mid-done: out_valid=%0b in_ready=%0b q=0x%02h", out_valid, in_ready, quotient);
    check("done_reset_out_valid", out_valid, 1'b0);
    check("done_reset_in_ready", in_ready, 1'b1);
    check("done_reset_quotient", quotient, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present on dividend/divisor/is_signed.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 dividend  input  WIDTH  numerator.
REQ-007 divisor  input  WIDTH  denominator.
REQ-008 is_signed  input  1  1: both operands two's complement; 0: both unsigned.
REQ-009 out_valid  output  1  quotient/remainder valid.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 quotient  output  WIDTH  result quotient, truncated toward zero.
REQ-012 remainder  output  WIDTH  result remainder, sign follows dividend.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-014 IDLE: in_ready=1, out_valid=0; in_valid=1 SHALL latch operands and is_signed, go to CALC, clear step counter.
REQ-015 At latch, signed mode SHALL store operand magnitudes plus quotient-negate flag (sign(dividend) XOR sign(divisor)) and remainder-negate flag (sign(dividend)).
REQ-016 CALC: one restoring step per cycle, MSB first -- shift partial remainder left with next dividend bit, subtract |divisor| if result non-negative, shift quotient bit in.
REQ-017 CALC SHALL last exactly WIDTH cycles regardless of operands; out_valid first high WIDTH cycles after the accepting edge (8 for WIDTH=8).
REQ-018 On leaving CALC, quotient/remainder registers SHALL hold sign-corrected final values; outputs driven directly from registers.
REQ-019 DONE: out_valid=1, in_ready=0; outputs stable while out_ready=0; out_valid&out_ready SHALL return to IDLE.
REQ-020 in_ready SHALL be 0 in CALC and DONE; in_valid there is ignored and inputs not sampled.
REQ-021 Divisor zero: quotient SHALL be all ones, remainder = dividend (unmodified), both modes, same fixed latency.
REQ-022 Signed overflow (dividend = most-negative, divisor = -1): quotient = most-negative, remainder = 0.
REQ-023 Unsigned results SHALL equal floor division and modulo; signed results match RISC-V DIV/REM semantics.
REQ-024 New request not accepted in the cycle DONE hands off; earliest next accept is the following cycle (IDLE).

Reset
REQ-025 reset=1 SHALL force IDLE, clear counter, quotient=0, remainder=0, out_valid=0, in_ready=1 (after edge).
REQ-026 reset mid-CALC or mid-DONE SHALL abandon the operation with no result ever presented.
REQ-027 reset has priority over in_valid and out_ready in the same cycle.

Structure
REQ-028 Package divider_pkg SHALL hold the state enum (IDLE/CALC/DONE) and default WIDTH constant.
REQ-029 One combinational sub-module divider_step SHALL implement a single restoring step (partial remainder, divisor, next bit -> new remainder, quotient bit).
REQ-030 Step counter width SHALL be clog2(WIDTH)+1 bits.

Verification
REQ-031 Unsigned 0xFF / 0x01 -> quotient 0xFF, remainder 0x00, out_valid exactly 8 cycles after accept.
REQ-032 Signed 0xF9 (-7) / 0x02 -> quotient 0xFD (-3), remainder 0xFF (-1); unsigned same operands -> quotient 0x7C, remainder 0x01.
REQ-033 Divide by zero, signed 0x85 / 0x00 -> quotient 0xFF, remainder 0x85.
REQ-034 Signed 0x80 / 0xFF -> quotient 0x80, remainder 0x00.
REQ-035 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no new accept; release -> IDLE next cycle.
REQ-036 Assert reset at CALC step 4 -> next cycle IDLE, out_valid=0, outputs 0; subsequent request 0x64/0x07 -> quotient 0x0E, remainder 0x02.
